seq_divider: RTL

Sequential unsigned restoring divider, the inverse of the team's shift-add multiplier. It computes quotient and remainder of two WIDTH-bit operands, one bit per SHIFT/SUBTRACT state pair. It uses the same Moore-style controller split: a 2-bit state register, a combinational next-state block and combinational control decode. The block sits beside the multiplier in the arithmetic unit and is started by a one-cycle request from the issuing logic.

---
 rtl/seq_divider.sv | 113 +++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per SHIFT/SUBTRACT pair.
// Moore controller with a 2-bit state register, combinational next-state and decode.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o,
    output logic [1:0]       state_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SHIFT    = 2'b01,
        SUBTRACT = 2'b10,
        DONE     = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH+1:0] diff;

    // Trial subtraction; a set MSB means the divisor did not fit and rem is restored.
    function automatic logic [WIDTH+1:0] trial_sub(input logic [WIDTH:0] r,
                                                   input logic [WIDTH-1:0] d);
        trial_sub = {1'b0, r} - {2'b00, d};
    endfunction

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        count_d = count_q;
        dbz_d   = dbz_q;
        diff    = trial_sub(rem_q, dvsr_q);
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    rem_d   = '0;
                    quo_d   = dividend_i;
                    dvsr_d  = divisor_i;
                    count_d = '0;
                    dbz_d   = (divisor_i == '0);
                    if (divisor_i == '0) begin
                        quo_d   = '1;
                        rem_d   = {1'b0, dividend_i};
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                {rem_d, quo_d} = {rem_q[WIDTH-1:0], quo_q, 1'b0};
                state_d        = SUBTRACT;
            end
            SUBTRACT: begin
                if (!diff[WIDTH+1]) begin
                    rem_d    = diff[WIDTH:0];
                    quo_d[0] = 1'b1;
                end
                count_d = count_q + 1'b1;
                state_d = (count_q == CW'(WIDTH - 1)) ? DONE : SHIFT;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o        = (state_q == SHIFT) || (state_q == SUBTRACT);
        done_o        = (state_q == DONE);
        quotient_o    = quo_q;
        remainder_o   = rem_q[WIDTH-1:0];
        div_by_zero_o = dbz_q;
        state_o       = state_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            count_q <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            count_q <= count_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule
